operand_read_unit: RTL and testbench
====================================

OPERAND_READ_UNIT -- requirements
Module: operand_read_unit

Interface
REQ-001 SHALL have parameter DW, default 16, register data width.
REQ-002 SHALL have parameter NREGS, default 8, register count; AW = clog2(NREGS) = 3.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid  input  1 and in_ready  output  1  decoded-instruction handshake.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  AW each  source and destination register indices.
REQ-007 SHALL have ports in_use_rs1, in_use_rs2, in_iswb, in_isld  input  1 each  operand-use and writeback/load flags.
REQ-008 SHALL have ports wb_en  input  1, wb_rd  input  AW, wb_data  input  DW  writeback write port.
REQ-009 SHALL have ports out_valid  output  1 and out_ready  input  1  execute-side handshake.
REQ-010 SHALL have ports out_rs1_val, out_rs2_val  output  DW and out_rd  output  AW, out_iswb, out_isld  output  1  registered operand bundle.

Function
REQ-011 SHALL hold an NREGS x DW register file written only through the wb port: wb_en at edge writes wb_data to reg[wb_rd].
REQ-012 SHALL hold a busy bit per register (scoreboard); busy[r]=1 means an issued instruction has a pending writeback to r.
REQ-013 SHALL flag hazard when (in_use_rs1 & busy[in_rs1] & !hit1) | (in_use_rs2 & busy[in_rs2] & !hit2) | (in_iswb & busy[in_rd] & !hitd), where hitN = BYPASS_EN & wb_en & wb_rd==index.
REQ-014 SHALL drive in_ready = !hazard & (!out_valid | out_ready), combinationally.
REQ-015 SHALL accept when in_valid & in_ready; the bundle appears on out_* the next cycle with out_valid=1 (latency 1).
REQ-016 SHALL select operand value = wb_data when bypass hit on that index, else reg[index]; unused operands SHALL output 0.
REQ-017 SHALL hold out_* stable while out_valid & !out_ready; clear out_valid on out_ready with no new accept.
REQ-018 SHALL set busy[in_rd] on accept with in_iswb; SHALL clear busy[wb_rd] on wb_en.
REQ-019 SHALL, on same-cycle set and clear of the same register, leave busy=1 (set wins); register data still written.
REQ-020 SHALL ignore wb_en to a non-busy register for scoreboard purposes but still write the register file.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear all registers to 0, all busy bits to 0, out_valid to 0, out_* data/index/flags to 0.
REQ-022 SHALL discard any in-flight bundle on reset mid-stall; in_ready SHALL be 1 after reset release with no pending hazard.

Configuration
REQ-023 SHALL compile writeback-to-read same-cycle forwarding only when macro OPERAND_READ_BYPASS_EN is defined.
REQ-024 SHALL, with OPERAND_READ_BYPASS_EN, treat hitN per REQ-013/016; without it, hitN=0 and a dependent instruction accepts the cycle after wb_en, reading the file.

Structure
REQ-025 SHALL take DW, NREGS, AW constants and the operand bundle struct from shared package proc_pkg.
REQ-026 SHALL isolate the busy-bit array and hazard logic in sub-module scoreboard.

Verification
REQ-027 SHALL cover: reset, wb r3=0x1234, issue use_rs1 rs1=3 -> out_rs1_val=0x1234, out_valid one cycle after accept.
REQ-028 SHALL cover: issue iswb rd=5, then use rs2=5 -> in_ready=0 until wb_en rd=5 data 0xBEEF; with bypass accepted that cycle, rs2_val=0xBEEF; without, accepted next cycle.
REQ-029 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0, no busy bits set.
REQ-030 SHALL cover: accept iswb rd=2 while wb_en rd=2 same cycle -> busy[2]=1 afterwards, reg[2] holds wb_data.
REQ-031 SHALL cover: WAW issue iswb rd=4 twice -> second stalls until wb rd=4.
REQ-032 SHALL cover: rst_n low mid-stall -> out_valid=0, busy all 0, reg[*]=0 immediately.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg
//   Shared constants and types for the operand read stage.
//   DW     : register data width
//   NREGS  : architectural register count
//   AW     : register index width, clog2(NREGS)
//   operand_bundle_t : registered bundle handed from operand read to execute
//
//   Forwarding from the writeback port is compiled in only when the macro
//   OPERAND_READ_BYPASS_EN is defined (see scoreboard.sv).

package proc_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  typedef struct packed {
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [AW-1:0] rd;
    logic          iswb;
    logic          isld;
  } operand_bundle_t;

  localparam operand_bundle_t BUNDLE_RESET = '0;

endpackage

// File: rtl/operand_read_unit_scoreboard.sv
// scoreboard
//   Busy-bit array and hazard detection for the operand read stage.
//   A busy bit marks a register with an issued-but-not-yet-written result.
//
//   Configuration macro: OPERAND_READ_BYPASS_EN
//     defined   : a writeback in the same cycle satisfies a dependency
//                 (hit1/hit2/hitd may be 1)
//     undefined : hit outputs are tied to 0; dependents wait for the cycle
//                 after the writeback and read the register file
//
//   Ports
//     clk, rst_n          : clock, asynchronous active-low reset
//     use_rs1/use_rs2     : instruction reads rs1/rs2
//     iswb                : instruction writes rd
//     rs1, rs2, rd        : register indices of the presented instruction
//     set_en              : instruction accepted with writeback -> mark rd busy
//     wb_en, wb_rd        : writeback port, clears busy[wb_rd]
//     hit1, hit2          : same-cycle forwarding hit for rs1/rs2
//     hazard              : presented instruction may not be accepted

module scoreboard
  import proc_pkg::*;
#(
  parameter int NREGS = proc_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          use_rs1,
  input  logic          use_rs2,
  input  logic          iswb,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          set_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  output logic          hit1,
  output logic          hit2,
  output logic          hazard
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             hitd;

`ifdef OPERAND_READ_BYPASS_EN
  assign hit1 = wb_en && (wb_rd == rs1);
  assign hit2 = wb_en && (wb_rd == rs2);
  assign hitd = wb_en && (wb_rd == rd);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign hitd = 1'b0;
`endif

  // A destination that is still busy also stalls (WAW), so the busy bit
  // never has to count more than one outstanding writer per register.
  always_comb begin
    hazard = (use_rs1 && busy[rs1] && !hit1) ||
             (use_rs2 && busy[rs2] && !hit2) ||
             (iswb    && busy[rd]  && !hitd);
  end

  // Clear is applied before set so that a same-cycle set of the register
  // being written back leaves it busy for the newly issued writer.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (set_en) begin
      busy_next[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/operand_read_unit.sv
// operand_read_unit
//   Operand read stage: register file, scoreboard-based issue stall and a
//   one-entry output register towards execute (latency 1 from accept).
//
//   Configuration macro: OPERAND_READ_BYPASS_EN enables forwarding of the
//   writeback port to a same-cycle operand read.
//
//   Ports
//     clk, rst_n                      : clock, asynchronous active-low reset
//     in_valid / in_ready             : decoded-instruction handshake
//     in_rs1, in_rs2, in_rd           : source / destination indices
//     in_use_rs1, in_use_rs2          : operand-use flags
//     in_iswb, in_isld                : writeback / load flags
//     wb_en, wb_rd, wb_data           : register file write port
//     out_valid / out_ready           : execute-side handshake
//     out_rs1_val, out_rs2_val        : operand values (0 when unused)
//     out_rd, out_iswb, out_isld      : forwarded instruction fields
//
//   DW/NREGS overrides must match proc_pkg, which sizes operand_bundle_t.

module operand_read_unit #(
  parameter int DW    = proc_pkg::DW,
  parameter int NREGS = proc_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_use_rs1,
  input  logic          in_use_rs2,
  input  logic          in_iswb,
  input  logic          in_isld,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_rs1_val,
  output logic [DW-1:0] out_rs2_val,
  output logic [AW-1:0] out_rd,
  output logic          out_iswb,
  output logic          out_isld
);

  import proc_pkg::*;

  logic [DW-1:0]   regs [NREGS];
  logic            hazard;
  logic            hit1;
  logic            hit2;
  logic            accept;
  logic [DW-1:0]   rs1_val;
  logic [DW-1:0]   rs2_val;
  operand_bundle_t bundle_next;
  operand_bundle_t bundle_q;

  scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .use_rs1 (in_use_rs1),
    .use_rs2 (in_use_rs2),
    .iswb    (in_iswb),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .rd      (in_rd),
    .set_en  (accept && in_iswb),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .hit1    (hit1),
    .hit2    (hit2),
    .hazard  (hazard)
  );

  // The output register can take a new bundle when empty or being drained.
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Operand select; a hit means the value is arriving on the writeback port
  // this very cycle and is not yet in the file.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (in_use_rs1) begin
      rs1_val = hit1 ? wb_data : regs[in_rs1];
    end
    if (in_use_rs2) begin
      rs2_val = hit2 ? wb_data : regs[in_rs2];
    end
  end

  always_comb begin
    bundle_next         = BUNDLE_RESET;
    bundle_next.rs1_val = rs1_val;
    bundle_next.rs2_val = rs2_val;
    bundle_next.rd      = in_rd;
    bundle_next.iswb    = in_iswb;
    bundle_next.isld    = in_isld;
  end

  // Bundle data is only reloaded on accept, so it stays stable while
  // execute back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bundle_q  <= BUNDLE_RESET;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle_q  <= bundle_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1_val = bundle_q.rs1_val;
  assign out_rs2_val = bundle_q.rs2_val;
  assign out_rd      = bundle_q.rd;
  assign out_iswb    = bundle_q.iswb;
  assign out_isld    = bundle_q.isld;

endmodule

// File: tb/tb_operand_read_unit.sv
// tb_operand_read_unit
//   Directed bench for operand_read_unit with a behavioural reference model
//   (register array, busy array, one-entry output slot). A compare process
//   checks in_ready every cycle and the output bundle whenever it is valid;
//   hand-computed literal checks pin the key scenarios.
//   Follows OPERAND_READ_BYPASS_EN the same way as the design.

module tb_operand_read_unit;

`ifdef OPERAND_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [2:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_iswb, in_isld;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] out_rs1_val, out_rs2_val;
  logic [2:0]  out_rd;
  logic        out_iswb, out_isld;

  int checks_total  = 0;
  int checks_passed = 0;

  operand_read_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_use_rs1  (in_use_rs1),
    .in_use_rs2  (in_use_rs2),
    .in_iswb     (in_iswb),
    .in_isld     (in_isld),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_rd      (out_rd),
    .out_iswb    (out_iswb),
    .out_isld    (out_isld)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;
  logic        m_valid;
  logic [15:0] m_rs1, m_rs2;
  logic [2:0]  m_rd;
  logic        m_iswb, m_isld;

  function automatic logic m_hit(input logic [2:0] idx);
    return BYP && wb_en && (wb_rd == idx);
  endfunction

  function automatic logic m_ready();
    logic blocked;
    blocked = (in_use_rs1 && m_busy[in_rs1] && !m_hit(in_rs1)) ||
              (in_use_rs2 && m_busy[in_rs2] && !m_hit(in_rs2)) ||
              (in_iswb    && m_busy[in_rd]  && !m_hit(in_rd));
    return !blocked && (!m_valid || out_ready);
  endfunction

  function automatic logic [15:0] m_operand(input logic use_it, input logic [2:0] idx);
    if (!use_it) return 16'h0;
    if (m_hit(idx)) return wb_data;
    return m_reg[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= 16'h0;
      m_busy  <= 8'h0;
      m_valid <= 1'b0;
      m_rs1   <= 16'h0;
      m_rs2   <= 16'h0;
      m_rd    <= 3'd0;
      m_iswb  <= 1'b0;
      m_isld  <= 1'b0;
    end else begin
      if (in_valid && m_ready()) begin
        m_valid <= 1'b1;
        m_rs1   <= m_operand(in_use_rs1, in_rs1);
        m_rs2   <= m_operand(in_use_rs2, in_rs2);
        m_rd    <= in_rd;
        m_iswb  <= in_iswb;
        m_isld  <= in_isld;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      if (wb_en) begin
        m_busy[wb_rd] <= 1'b0;
        m_reg[wb_rd]  <= wb_data;
      end
      // later assignment wins: a new writer keeps the register busy
      if (in_valid && m_ready() && in_iswb) m_busy[in_rd] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Compare process: inputs change just after the rising edge, so the
  // falling edge sees settled inputs and settled registered outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model in_ready", {31'h0, in_ready}, {31'h0, m_ready()});
      checkOutput("model out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      if (m_valid) begin
        checkOutput("model out_rs1_val", {16'h0, out_rs1_val}, {16'h0, m_rs1});
        checkOutput("model out_rs2_val", {16'h0, out_rs2_val}, {16'h0, m_rs2});
        checkOutput("model out_rd", {29'h0, out_rd}, {29'h0, m_rd});
        checkOutput("model out_iswb", {31'h0, out_iswb}, {31'h0, m_iswb});
        checkOutput("model out_isld", {31'h0, out_isld}, {31'h0, m_isld});
      end
    end
  end

  task automatic applyStimulus(input logic v,
                               input logic u1, input logic [2:0] r1,
                               input logic u2, input logic [2:0] r2,
                               input logic wb, input logic [2:0] d, input logic ld,
                               input logic we, input logic [2:0] wr, input logic [15:0] wd,
                               input logic ordy);
    in_valid   = v;
    in_use_rs1 = u1;
    in_rs1     = r1;
    in_use_rs2 = u2;
    in_rs2     = r2;
    in_iswb    = wb;
    in_rd      = d;
    in_isld    = ld;
    wb_en      = we;
    wb_rd      = wr;
    wb_data    = wd;
    out_ready  = ordy;
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(0, 0,0, 0,0, 0,0,0, 0,0,16'h0, ordy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReady(input string name, input logic expected);
    #1;
    checkOutput(name, {31'h0, in_ready}, {31'h0, expected});
  endtask

  initial begin
    idle(1'b1);
    #12;
    // reset values
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset out_rs1_val", {16'h0, out_rs1_val}, 32'h0);
    checkOutput("reset out_rd", {29'h0, out_rd}, 32'h0);
    rst_n = 1'b1;
    tick();

    idle(1'b1);
    checkReady("ready after reset", 1'b1);
    tick();

    // write r3 = 0x1234, then read it as rs1
    applyStimulus(0, 0,0, 0,0, 0,0,0, 1,3'd3,16'h1234, 1);
    tick();
    applyStimulus(1, 1,3'd3, 0,0, 0,3'd0,0, 0,0,16'h0, 1);
    checkReady("rs1=3 ready", 1'b1);
    tick();
    checkOutput("rs1=3 out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("rs1=3 value", {16'h0, out_rs1_val}, 32'h1234);
    checkOutput("unused rs2 zero", {16'h0, out_rs2_val}, 32'h0);

    // issue writer of r5, dependent reader stalls until writeback
    applyStimulus(1, 0,0, 0,0, 1,3'd5,0, 0,0,16'h0, 1);
    tick();
    checkOutput("writer out_rd", {29'h0, out_rd}, 32'h5);
    checkOutput("writer out_iswb", {31'h0, out_iswb}, 32'h1);
    applyStimulus(1, 0,0, 1,3'd5, 0,3'd0,0, 0,0,16'h0, 1);
    checkReady("raw stall 1", 1'b0);
    tick();
    checkReady("raw stall 2", 1'b0);
    tick();
    applyStimulus(1, 0,0, 1,3'd5, 0,3'd0,0, 1,3'd5,16'hBEEF, 1);
`ifdef OPERAND_READ_BYPASS_EN
    checkReady("raw bypass accept", 1'b1);
    tick();
`else
    checkReady("raw wb cycle stall", 1'b0);
    tick();
    applyStimulus(1, 0,0, 1,3'd5, 0,3'd0,0, 0,0,16'h0, 1);
    checkReady("raw accept after wb", 1'b1);
    tick();
`endif
    checkOutput("raw rs2 value", {16'h0, out_rs2_val}, 32'hBEEF);

    // output back-pressure for three cycles
    idle(1'b1);
    tick();
    applyStimulus(1, 1,3'd3, 0,0, 0,3'd1,1, 0,0,16'h0, 0);
    tick();
    checkOutput("bp first out_isld", {31'h0, out_isld}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0,0, 0,0, 1,3'd6,0, 0,0,16'h0, 0);
      checkReady("bp in_ready low", 1'b0);
      tick();
      checkOutput("bp held out_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("bp held rs1", {16'h0, out_rs1_val}, 32'h1234);
      checkOutput("bp held rd", {29'h0, out_rd}, 32'h1);
    end
    idle(1'b1);
    tick();
    checkOutput("bp drained", {31'h0, out_valid}, 32'h0);
    applyStimulus(1, 0,0, 0,0, 1,3'd6,0, 0,0,16'h0, 1);
    checkReady("bp no busy leaked", 1'b1);
    tick();
    applyStimulus(0, 0,0, 0,0, 0,0,0, 1,3'd6,16'h0066, 1);
    tick();

    // accept writer of r2 while r2 is written back: set wins
    applyStimulus(1, 0,0, 0,0, 1,3'd2,0, 1,3'd2,16'h0A0A, 1);
    checkReady("same-cycle set ready", 1'b1);
    tick();
    applyStimulus(1, 1,3'd2, 0,0, 0,3'd0,0, 0,0,16'h0, 1);
    checkReady("r2 still busy", 1'b0);
    tick();
    applyStimulus(1, 1,3'd2, 0,0, 0,3'd0,0, 1,3'd2,16'h0A0A, 1);
`ifndef OPERAND_READ_BYPASS_EN
    tick();
    applyStimulus(1, 1,3'd2, 0,0, 0,3'd0,0, 0,0,16'h0, 1);
`endif
    checkReady("r2 released", 1'b1);
    tick();
    checkOutput("r2 value", {16'h0, out_rs1_val}, 32'h0A0A);

    // WAW on r4
    applyStimulus(1, 0,0, 0,0, 1,3'd4,0, 0,0,16'h0, 1);
    tick();
    applyStimulus(1, 0,0, 0,0, 1,3'd4,0, 0,0,16'h0, 1);
    checkReady("waw stall 1", 1'b0);
    tick();
    checkReady("waw stall 2", 1'b0);
    tick();
    applyStimulus(1, 0,0, 0,0, 1,3'd4,0, 1,3'd4,16'h4444, 1);
`ifndef OPERAND_READ_BYPASS_EN
    checkReady("waw wb cycle stall", 1'b0);
    tick();
    applyStimulus(1, 0,0, 0,0, 1,3'd4,0, 0,0,16'h0, 1);
`endif
    checkReady("waw second accept", 1'b1);
    tick();
    applyStimulus(1, 1,3'd4, 0,0, 0,3'd0,0, 0,0,16'h0, 1);
    checkReady("r4 busy for second writer", 1'b0);
    tick();

    // reset in the middle of a back-pressured stall
    applyStimulus(1, 1,3'd7, 0,0, 0,3'd3,0, 0,0,16'h0, 0);
    tick();
    applyStimulus(1, 1,3'd4, 0,0, 0,3'd0,0, 0,0,16'h0, 0);
    checkReady("pre-reset stall", 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("mid reset out_rd", {29'h0, out_rd}, 32'h0);
    checkOutput("mid reset busy cleared", {31'h0, in_ready}, 32'h1);
    idle(1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    checkReady("ready after release", 1'b1);
    applyStimulus(1, 1,3'd3, 1,3'd5, 0,3'd0,0, 0,0,16'h0, 1);
    tick();
    checkOutput("r3 cleared", {16'h0, out_rs1_val}, 32'h0);
    checkOutput("r5 cleared", {16'h0, out_rs2_val}, 32'h0);

    // boundary indices and values
    applyStimulus(0, 0,0, 0,0, 0,0,0, 1,3'd7,16'hFFFF, 1);
    tick();
    applyStimulus(0, 0,0, 0,0, 0,0,0, 1,3'd0,16'h8001, 1);
    tick();
    applyStimulus(1, 1,3'd7, 1,3'd0, 0,3'd7,1, 0,0,16'h0, 1);
    tick();
    checkOutput("r7 value", {16'h0, out_rs1_val}, 32'hFFFF);
    checkOutput("r0 value", {16'h0, out_rs2_val}, 32'h8001);
    applyStimulus(1, 1,3'd0, 0,0, 0,3'd0,0, 1,3'd0,16'h0002, 1);
    tick();
    idle(1'b1);
    tick();
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
